// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared types and helpers for the 1-to-N stream demux
package stream_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROUTE   = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1 so a select field is never zero bits wide.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry registered output slot with valid/ready
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              can_accept
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  // A new load always wins over a same-cycle drain; payload holds when not loaded.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign m_valid    = valid_q;
  assign m_data     = data_q;
  assign m_last     = last_q;
  assign can_accept = ~valid_q | m_ready;

endmodule

// File: rtl/stream_demux_1ton.sv
// rtl/stream_demux_1ton.sv - registered 1-to-N packet demux with discard of bad selects
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int CNT_W  = 8,
  parameter int SEL_W  = clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_last,
  output logic [N_OUT-1:0]        m_valid,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic [N_OUT-1:0]        m_last,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    busy
);

  localparam logic [SEL_W:0] N_OUT_W = (SEL_W + 1)'(N_OUT);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             sel_in_range;
  logic [SEL_W-1:0] target;
  logic             tgt_rdy;
  logic             accept;
  logic             route_beat;
  logic [N_OUT-1:0] slot_rdy;
  logic [N_OUT-1:0] slot_load;

  assign sel_in_range = ({1'b0, s_sel} < N_OUT_W);

  // Inside a packet the latched destination steers; otherwise the live select does.
  assign target = (state_q == ST_ROUTE) ? cur_sel_q : s_sel;

  // Pick the target slot's readiness; out-of-range targets read as not ready here.
  always_comb begin
    tgt_rdy = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (target == SEL_W'(k)) tgt_rdy = slot_rdy[k];
    end
  end

  // Ingress ready depends only on state, select and slot occupancy, never on s_valid.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      ST_IDLE:    s_ready = sel_in_range ? tgt_rdy : 1'b1;
      ST_ROUTE:   s_ready = tgt_rdy;
      ST_DISCARD: s_ready = 1'b1;
      default:    s_ready = 1'b0;
    endcase
  end

  assign accept     = s_valid & s_ready;
  assign route_beat = (state_q == ST_ROUTE) | ((state_q == ST_IDLE) & sel_in_range);

  // Only the target slot is written; all other slots drain on their own.
  always_comb begin
    slot_load = '0;
    for (int k = 0; k < N_OUT; k++) begin
      slot_load[k] = accept & route_beat & (target == SEL_W'(k));
    end
  end

  // Packet FSM, destination latch and saturating per-packet drop counter.
  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (sel_in_range) begin
            if (!s_last) begin
              state_d   = ST_ROUTE;
              cur_sel_d = s_sel;
            end
          end else begin
            if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            if (!s_last) state_d = ST_DISCARD;
          end
        end
      end
      ST_ROUTE, ST_DISCARD: begin
        if (accept && s_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_sel_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != ST_IDLE);

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_out_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (slot_load[k]),
      .in_data    (s_data),
      .in_last    (s_last),
      .m_valid    (m_valid[k]),
      .m_ready    (m_ready[k]),
      .m_data     (m_data[k*DATA_W +: DATA_W]),
      .m_last     (m_last[k]),
      .can_accept (slot_rdy[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb/tb_stream_demux_1ton.sv - self-checking bench for stream_demux_1ton
module tb_stream_demux_1ton;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: 8 channels, 8-bit counter.
  logic        a_s_valid, a_s_ready, a_s_last;
  logic [7:0]  a_s_data;
  logic [2:0]  a_s_sel;
  logic [7:0]  a_m_valid, a_m_ready, a_m_last;
  logic [63:0] a_m_data;
  logic [7:0]  a_drop;
  logic        a_busy;

  // Instance B: 6 channels, 2-bit counter.
  logic        b_s_valid, b_s_ready, b_s_last;
  logic [7:0]  b_s_data;
  logic [2:0]  b_s_sel;
  logic [5:0]  b_m_valid, b_m_ready, b_m_last;
  logic [47:0] b_m_data;
  logic [1:0]  b_drop;
  logic        b_busy;

  stream_demux_1ton #(.DATA_W(8), .N_OUT(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_sel(a_s_sel), .s_last(a_s_last),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last),
    .drop_cnt(a_drop), .busy(a_busy)
  );

  stream_demux_1ton #(.DATA_W(8), .N_OUT(6), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_sel(b_s_sel), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .drop_cnt(b_drop), .busy(b_busy)
  );

  // Reference model for A: per-channel queue of beats accepted but not yet consumed.
  typedef logic [8:0] beat_t;
  beat_t a_q [8][$];
  bit    a_open = 1'b0;
  int    a_cur = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_drive(input bit v, input int sel, input logic [7:0] d, input bit l);
    a_s_valid = v;
    a_s_sel   = 3'(sel);
    a_s_data  = d;
    a_s_last  = l;
  endtask

  task automatic a_model_reset();
    for (int k = 0; k < 8; k++) a_q[k].delete();
    a_open = 1'b0;
    a_cur  = 0;
  endtask

  // One clock of A: check against the model at the falling edge, then advance the model.
  task automatic a_cycle();
    int tgt;
    bit exp_rdy;
    @(negedge clk);
    tgt = a_open ? a_cur : int'(a_s_sel);
    exp_rdy = (a_q[tgt].size() == 0) || a_m_ready[tgt];
    chk("a_s_ready", 64'(a_s_ready), 64'(exp_rdy));
    chk("a_busy", 64'(a_busy), 64'(a_open));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("a_m_valid[%0d]", k), 64'(a_m_valid[k]), 64'(a_q[k].size() != 0));
      if (a_m_valid[k] && a_m_ready[k] && a_q[k].size() != 0) begin
        chk($sformatf("a_beat[%0d]", k), 64'({a_m_last[k], a_m_data[k*8 +: 8]}), 64'(a_q[k][0]));
        void'(a_q[k].pop_front());
      end
    end
    if (a_s_valid && exp_rdy) begin
      a_q[tgt].push_back({a_s_last, a_s_data});
      a_open = !a_s_last;
      a_cur  = tgt;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_drive(0, 0, 8'h00, 0);
    a_m_ready = 8'hFF;
    b_s_valid = 0; b_s_sel = 0; b_s_data = 0; b_s_last = 0;
    b_m_ready = 6'h3F;

    // Reset state.
    @(posedge clk);
    #1;
    chk("rst_a_m_valid", 64'(a_m_valid), 64'h0);
    chk("rst_a_busy", 64'(a_busy), 64'h0);
    chk("rst_a_drop", 64'(a_drop), 64'h0);
    chk("rst_a_s_ready", 64'(a_s_ready), 64'h1);
    chk("rst_b_m_valid", 64'(b_m_valid), 64'h0);
    chk("rst_b_drop", 64'(b_drop), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Discard on B: 3-beat packet with sel=7; later beats carry an in-range select.
    for (int i = 0; i < 3; i++) begin
      b_s_valid = 1; b_s_sel = (i == 0) ? 3'd7 : 3'd0; b_s_data = 8'(8'hD0 + i); b_s_last = (i == 2);
      @(negedge clk);
      chk("disc_s_ready", 64'(b_s_ready), 64'h1);
      chk("disc_m_valid", 64'(b_m_valid), 64'h0);
      @(posedge clk);
      #1;
      chk("disc_drop", 64'(b_drop), 64'h1);
      chk("disc_busy", 64'(b_busy), 64'(i != 2));
      chk("disc_m_valid_post", 64'(b_m_valid), 64'h0);
    end
    b_s_valid = 1; b_s_sel = 3'd0; b_s_data = 8'h5A; b_s_last = 1;
    @(negedge clk);
    chk("after_disc_s_ready", 64'(b_s_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("after_disc_m_valid", 64'(b_m_valid), 64'h01);
    chk("after_disc_data", 64'(b_m_data[7:0]), 64'h5A);
    chk("after_disc_last", 64'(b_m_last[0]), 64'h1);
    chk("after_disc_drop", 64'(b_drop), 64'h1);

    // Saturation on B: four more single-beat dropped packets.
    for (int i = 0; i < 4; i++) begin
      b_s_valid = 1; b_s_sel = (i % 2 == 0) ? 3'd6 : 3'd7; b_s_data = 8'(i); b_s_last = 1;
      @(posedge clk);
      #1;
      chk($sformatf("sat_drop_%0d", i), 64'(b_drop), 64'((i + 2 > 3) ? 3 : i + 2));
    end
    b_s_valid = 0;

    // Full sweep on A.
    a_model_reset();
    for (int sel = 0; sel < 8; sel++) begin
      a_drive(1, sel, 8'(8'hA0 + sel), 1);
      chk("sweep_s_ready", 64'(a_s_ready), 64'h1);
      a_cycle();
      chk("sweep_m_valid", 64'(a_m_valid[sel]), 64'h1);
      chk("sweep_lane", 64'(a_m_data[sel*8 +: 8]), 64'(8'hA0 + sel));
    end
    a_drive(0, 0, 8'h00, 0);
    a_cycle();

    // Packet lock: select changes after beat 0 must be ignored.
    for (int i = 0; i < 4; i++) begin
      a_drive(1, (i == 0) ? 3 : 5, 8'(8'h30 + i), (i == 3));
      a_cycle();
      chk("lock_ch5_idle", 64'(a_m_valid[5]), 64'h0);
      chk("lock_ch3_valid", 64'(a_m_valid[3]), 64'h1);
      chk("lock_ch3_data", 64'(a_m_data[31:24]), 64'(8'h30 + i));
      chk("lock_ch3_last", 64'(a_m_last[3]), 64'(i == 3));
    end
    a_drive(0, 0, 8'h00, 0);
    a_cycle();

    // Back-pressure on channel 1, then a packet to channel 4 while channel 1 stalls.
    a_m_ready = 8'hFD;
    a_drive(1, 1, 8'h11, 0);
    a_cycle();
    chk("bp_lane_first", 64'(a_m_data[15:8]), 64'h11);
    a_drive(1, 1, 8'h12, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_s_ready", 64'(a_s_ready), 64'h0);
      a_cycle();
      chk("bp_hold_data", 64'(a_m_data[15:8]), 64'h11);
      chk("bp_hold_valid", 64'(a_m_valid[1]), 64'h1);
    end
    a_m_ready = 8'hFF;
    a_cycle();
    a_drive(1, 1, 8'h13, 1);
    a_cycle();
    a_m_ready = 8'hFD;
    a_drive(1, 4, 8'h44, 1);
    chk("bp_switch_s_ready", 64'(a_s_ready), 64'h1);
    a_cycle();
    chk("bp_ch4_valid", 64'(a_m_valid[4]), 64'h1);
    chk("bp_ch4_data", 64'(a_m_data[39:32]), 64'h44);
    chk("bp_ch1_held", 64'(a_m_data[15:8]), 64'h13);
    a_m_ready = 8'hFF;
    a_drive(0, 0, 8'h00, 0);
    a_cycle();
    a_cycle();

    // Reset in the middle of a packet to channel 2.
    a_m_ready = 8'hFB;
    a_drive(1, 2, 8'h21, 0);
    a_cycle();
    chk("midrst_busy_before", 64'(a_busy), 64'h1);
    a_drive(1, 2, 8'h22, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(a_m_valid), 64'h0);
    chk("midrst_busy", 64'(a_busy), 64'h0);
    chk("midrst_drop", 64'(a_drop), 64'h0);
    chk("midrst_s_ready", 64'(a_s_ready), 64'h1);
    a_drive(0, 0, 8'h00, 0);
    a_model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_m_ready = 8'hFF;
    a_drive(1, 6, 8'h66, 1);
    a_cycle();
    chk("postrst_m_valid", 64'(a_m_valid), 64'h40);
    chk("postrst_lane", 64'(a_m_data[55:48]), 64'h66);
    a_drive(0, 0, 8'h00, 0);
    a_cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      a_drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 2) == 0);
      a_m_ready = 8'($urandom);
      a_cycle();
    end
    a_drive(0, 0, 8'h00, 0);
    a_m_ready = 8'hFF;
    for (int i = 0; i < 3; i++) a_cycle();
    chk("drain_m_valid", 64'(a_m_valid), 64'h0);
    chk("rand_drop", 64'(a_drop), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
